// File: rtl/keccak_digest_axis_tx.sv
// keccak_digest_axis_tx
// Captures the final Keccak state and streams the SHA-3 digest out over an
// AXI-Stream master, DATA_WIDTH bits per beat, least significant beat first.
// The lane mapping matches the input packer, so the stream can be looped back.

module keccak_digest_axis_tx #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic [0:4][0:4][63:0]    S_in,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic                     M_TREADY,
  output logic [DATA_WIDTH-1:0]    M_TDATA,
  output logic                     M_TVALID,
  output logic                     M_TLAST,
  output logic [1:0]               M_TUSER,
  output logic                     busy,
  output logic                     done,
  output logic                     start_drop
);

  // Only 8-, 16- and 32-bit beats tile every digest length exactly.
  if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32)) begin : g_bad_width
    $error("keccak_digest_axis_tx: DATA_WIDTH must be 8, 16 or 32");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t       state_q, state_d;
  logic [511:0] hold_q;      // digest bits still to send, next beat in the LSBs
  logic [5:0]   cnt_q;       // index of the beat currently presented
  logic [1:0]   user_q;      // mode of the digest in flight
  logic         done_q;
  logic         drop_q;

  logic [511:0] flat_lo;
  logic [5:0]   last_idx;
  logic         hs;
  logic         last_hs;
  logic         unused_lanes;

  // Index of the final beat for a given mode: digest bits / beat width - 1.
  function automatic logic [5:0] last_index(input logic [1:0] m);
    int d;
    case (m)
      2'd0:    d = 224;
      2'd1:    d = 256;
      2'd2:    d = 384;
      default: d = 512;
    endcase
    return 6'(d / DATA_WIDTH - 1);
  endfunction

  // Lanes x+5y = 0..7 form the low 512 bits of the flattened state; the
  // rest of the sponge never reaches the digest.
  always_comb begin
    flat_lo = '0;
    for (int i = 0; i < 8; i++) begin
      flat_lo[64*i +: 64] = S_in[i % 5][i / 5];
    end
  end

  assign unused_lanes = ^S_in;

  assign last_idx = last_index(user_q);
  assign hs       = (state_q == SEND) && M_TREADY;
  assign last_hs  = hs && (cnt_q == last_idx);

  // Next-state logic: a start opens a digest, the last handshake closes it.
  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)   state_d = SEND;
      SEND:    if (last_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Datapath: load on an accepted start, shift one beat per handshake.
  // The counter holds at the last index instead of stepping past it, so a
  // 64-beat digest never needs a seventh bit.
  // NOTE: the 512-bit holding register is reset too, so TDATA reads 0 out of reset.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      hold_q <= '0;
      cnt_q  <= '0;
      user_q <= '0;
    end else if (state_q == IDLE && start) begin
      hold_q <= flat_lo;
      cnt_q  <= '0;
      user_q <= mode;
    end else if (hs) begin
      hold_q <= hold_q >> DATA_WIDTH;
      if (!last_hs) cnt_q <= cnt_q + 6'd1;
    end
  end

  // Status pulses: done after the final handshake, start_drop for a start
  // that arrived mid-digest.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      done_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      done_q <= last_hs;
      drop_q <= start && (state_q == SEND);
    end
  end

  assign M_TVALID   = (state_q == SEND);
  assign M_TLAST    = (state_q == SEND) && (cnt_q == last_idx);
  assign M_TDATA    = hold_q[DATA_WIDTH-1:0];
  assign M_TUSER    = user_q;
  assign busy       = (state_q == SEND);
  assign done       = done_q;
  assign start_drop = drop_q;

endmodule

// File: tb/tb_keccak_digest_axis_tx.sv
// tb_keccak_digest_axis_tx
// Random and directed digests; a scoreboard queue of expected beats is
// filled from a plain reference model and drained by an independent monitor.

module tb_keccak_digest_axis_tx;

  localparam int DW = 16;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [1:0]    user;
  } beat_t;

  logic                  ACLK;
  logic                  ARESETn;
  logic [0:4][0:4][63:0] S_in;
  logic                  start;
  logic [1:0]            mode;
  logic                  M_TREADY;
  logic [DW-1:0]         M_TDATA;
  logic                  M_TVALID;
  logic                  M_TLAST;
  logic [1:0]            M_TUSER;
  logic                  busy;
  logic                  done;
  logic                  start_drop;

  keccak_digest_axis_tx #(.DATA_WIDTH(DW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .S_in(S_in), .start(start), .mode(mode),
    .M_TREADY(M_TREADY), .M_TDATA(M_TDATA), .M_TVALID(M_TVALID),
    .M_TLAST(M_TLAST), .M_TUSER(M_TUSER), .busy(busy), .done(done),
    .start_drop(start_drop)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  int    pops = 0;
  bit    exp_done = 0;
  bit    prev_stall = 0;
  int    ready_mode = 0;   // 0: always ready, 1: random, 2: pattern 1,0,0
  int    ready_phase = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: flatten the state lane by lane, cut d bits, slice beats.
  function automatic void push_digest(input logic [0:4][0:4][63:0] s, input logic [1:0] m);
    logic [1599:0] flat;
    int d, n;
    beat_t b;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        flat[64*(x+5*y) +: 64] = s[x][y];
    d = (m == 2'd0) ? 224 : (m == 2'd1) ? 256 : (m == 2'd2) ? 384 : 512;
    n = d / DW;
    for (int k = 0; k < n; k++) begin
      b.data = flat[DW*k +: DW];
      b.last = (k == n - 1);
      b.user = m;
      exp_q.push_back(b);
    end
  endfunction

  function automatic logic [0:4][0:4][63:0] rand_state();
    logic [0:4][0:4][63:0] s;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        s[x][y] = {$urandom, $urandom};
    return s;
  endfunction

  // Ready generator, updated just after each rising edge.
  initial begin
    M_TREADY = 1'b0;
    forever begin
      @(posedge ACLK);
      #1;
      case (ready_mode)
        0: M_TREADY = 1'b1;
        1: M_TREADY = 1'($urandom_range(0, 1));
        default: begin
          M_TREADY = (ready_phase == 0);
          ready_phase = (ready_phase + 1) % 3;
        end
      endcase
    end
  end

  // Monitor: samples on the falling edge, pops and compares on each handshake.
  initial begin
    beat_t         b;
    logic [DW-1:0] p_data;
    logic          p_last;
    logic [1:0]    p_user;
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        prev_stall = 0;
        exp_done   = 0;
        continue;
      end
      if (exp_done) check("done_pulse", done, 1);
      else if (done) check("spurious_done", done, 0);
      exp_done = 0;
      if (prev_stall) begin
        check("valid_held", M_TVALID, 1);
        check("data_stable", M_TDATA, p_data);
        check("last_stable", M_TLAST, p_last);
        check("user_stable", M_TUSER, p_user);
      end
      if (M_TVALID && M_TREADY) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          b = exp_q.pop_front();
          check("tdata", M_TDATA, b.data);
          check("tlast", M_TLAST, b.last);
          check("tuser", M_TUSER, b.user);
          exp_done = b.last;
          pops++;
        end
      end
      prev_stall = M_TVALID && !M_TREADY;
      p_data = M_TDATA;
      p_last = M_TLAST;
      p_user = M_TUSER;
    end
  end

  // Pulse start for one cycle; returns just after the sampling edge with
  // S_in and mode scrambled, since they may change freely afterwards.
  task automatic issue(input logic [0:4][0:4][63:0] s, input logic [1:0] m);
    S_in  = s;
    mode  = m;
    start = 1'b1;
    @(posedge ACLK);
    #1;
    start = 1'b0;
    S_in  = rand_state();
    mode  = 2'($urandom_range(0, 3));
  endtask

  task automatic run_tracked(input logic [0:4][0:4][63:0] s, input logic [1:0] m);
    push_digest(s, m);
    issue(s, m);
    check("first_valid_latency", M_TVALID, 1);
    check("busy_streaming", busy, 1);
  endtask

  // Returns inside the done cycle (just after the edge that raised done).
  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(posedge ACLK);
      #1;
      seen = done;
    end
    check("done_within_bound", seen, 1);
    check("gap_valid_low", M_TVALID, 0);
    check("gap_busy_low", busy, 0);
  endtask

  task automatic wait_pops(input int target);
    bit hit = 0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(posedge ACLK);
      #1;
      hit = (pops >= target);
    end
    check("beats_within_bound", hit, 1);
  endtask

  initial begin
    logic [0:4][0:4][63:0] s;
    ARESETn = 1'b0;
    start   = 1'b0;
    mode    = 2'd0;
    S_in    = '0;
    #23;
    check("rst_tvalid", M_TVALID, 0);
    check("rst_tlast", M_TLAST, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_drop", start_drop, 0);
    check("rst_tdata", M_TDATA, 0);
    check("rst_tuser", M_TUSER, 0);
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    @(posedge ACLK);
    #1;

    // T1: one lane set, SHA3-256, always ready.
    s = '0;
    s[0][0] = 64'h0123456789ABCDEF;
    run_tracked(s, 2'd1);
    check("t1_first_beat", M_TDATA, 16'hCDEF);
    check("t1_tuser", M_TUSER, 2'd1);
    wait_done();

    // T2 (also T6: started in the done cycle): SHA3-224 truncation.
    s = '0;
    s[3][0] = 64'hFFFF_FFFF_AAAA_5555;
    run_tracked(s, 2'd0);
    wait_done();

    // T3: SHA3-512 with ready toggling 1,0,0.
    ready_mode  = 2;
    ready_phase = 0;
    run_tracked(rand_state(), 2'd3);
    wait_done();
    ready_mode = 0;

    // T4: second start mid-digest is dropped.
    begin
      int base = pops;
      run_tracked(rand_state(), 2'd2);
      wait_pops(base + 5);
      S_in  = rand_state();
      mode  = 2'd0;
      start = 1'b1;
      @(posedge ACLK);
      #1;
      start = 1'b0;
      check("t4_drop_pulse", start_drop, 1);
      check("t4_still_busy", busy, 1);
      @(posedge ACLK);
      #1;
      check("t4_drop_clears", start_drop, 0);
      wait_done();
    end

    // T5: reset mid-digest aborts, then a fresh digest streams from beat 0.
    begin
      int base = pops;
      run_tracked(rand_state(), 2'd1);
      wait_pops(base + 7);
      #2;
      ARESETn = 1'b0;
      #1;
      check("t5_abort_valid", M_TVALID, 0);
      check("t5_abort_busy", busy, 0);
      check("t5_abort_last", M_TLAST, 0);
      exp_q.delete();
      exp_done = 0;
      repeat (3) @(posedge ACLK);
      #1;
      ARESETn = 1'b1;
      check("t5_no_done", done, 0);
      @(posedge ACLK);
      #1;
      check("t5_no_done_after", done, 0);
      run_tracked(rand_state(), 2'd1);
      wait_done();
    end

    // Randomized back-to-back digests under random backpressure.
    ready_mode = 1;
    for (int i = 0; i < 8; i++) begin
      run_tracked(rand_state(), 2'($urandom_range(0, 3)));
      wait_done();
    end
    ready_mode = 0;

    repeat (5) @(posedge ACLK);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    check("final_idle", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
